rf_wb_arbiter: RTL and testbench

//  Owns the single register-file write port (reg_wr_c/waddr/wdata). Arbitrates between pipeline

---
 rtl/rf_ctrl_pkg.sv | 19 +
 rtl/rf_aux_fifo.sv | 74 +++++++
 rtl/rf_wb_arbiter_chk.sv | 25 ++
 rtl/rf_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and sizes for the register-file write path.
package rf_ctrl_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t         addr;
    logic [XLEN-1:0]   data;
  } rf_wr_t;

  // Register x0 is hardwired to zero, so writes to it are never performed.
  function automatic logic is_x0(input reg_addr_t a);
    return (a == 5'd0);
  endfunction

endpackage

// File: rtl/rf_aux_fifo.sv
// Small synchronous FIFO of pending auxiliary register writes.
module rf_aux_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  rf_wr_t        wr_i,
  input  logic          pop_i,
  output rf_wr_t        head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  rf_wr_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s, pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == CW'(0));
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // Next-state for pointers and occupancy; pointers wrap since DEPTH is a power of two.
  always_comb begin
    push_s  = push_i && !full_o;
    pop_s   = pop_i && !empty_o;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_s) begin
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and storage registers; reset discards any queued entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= PW'(0);
      rptr_q  <= PW'(0);
      count_q <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push_s) begin
        mem_q[wptr_q] <= wr_i;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter_chk.sv
// Protocol checks for the register-file write arbiter.
module rf_wb_arbiter_chk #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic          clk,
  input logic          reset,
  input logic          pipe_wr_en_i,
  input logic          pipe_stall_i,
  input logic          aux_issue_i,
  input logic [4:0]    aux_issue_addr_i,
  input logic [31:0]   busy_i,
  input logic [CW-1:0] count_i
);

  a_stall_contract: assert property (@(posedge clk) disable iff (!reset)
    pipe_stall_i |-> !pipe_wr_en_i);

  a_issue_not_busy: assert property (@(posedge clk) disable iff (!reset)
    (aux_issue_i && (aux_issue_addr_i != 5'd0)) |-> !busy_i[aux_issue_addr_i]);

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count_i <= CW'(DEPTH));

endmodule

// File: rtl/rf_wb_arbiter.sv
// Owns the register-file write port: pipeline writeback has priority, aux writes
// drain from a FIFO, a scoreboard tracks outstanding aux destinations.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int AUX_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_wr_en_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic        aux_valid_i,
  output logic        aux_ready_o,
  input  logic [4:0]  aux_waddr_i,
  input  logic [31:0] aux_wdata_i,
  input  logic        aux_issue_i,
  input  logic [4:0]  aux_issue_addr_i,
  input  logic [4:0]  chk_addr_1_i,
  input  logic [4:0]  chk_addr_2_i,
  output logic        hazard_o,
  output logic        pipe_stall_o,
  output logic        rf_wr_c_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  localparam int PW = $clog2(AUX_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  rf_wr_t                aux_wr_s;
  rf_wr_t                fifo_head_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [CW-1:0]         fifo_count_s;
  logic                  enq_s, head_win_s;

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  rf_wr_c_q, rf_wr_c_d;
  reg_addr_t             rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

  assign aux_wr_s     = '{addr: aux_waddr_i, data: aux_wdata_i};
  assign aux_ready_o  = !fifo_full_s;
  assign hazard_o     = busy_q[chk_addr_1_i] | busy_q[chk_addr_2_i];
  assign pipe_stall_o = (starve_q == SW'(STARVE_LIMIT));
  assign rf_wr_c_o    = rf_wr_c_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;

  rf_aux_fifo #(.DEPTH(AUX_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (enq_s),
    .wr_i    (aux_wr_s),
    .pop_i   (head_win_s),
    .head_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Arbitration: pipeline first, then FIFO head; x0 aux writes are accepted but never queued.
  always_comb begin
    head_win_s = !pipe_wr_en_i && !fifo_empty_s;
    enq_s      = aux_valid_i && !fifo_full_s && !is_x0(aux_waddr_i);
    rf_wr_c_d  = 1'b0;
    rf_waddr_d = 5'd0;
    rf_wdata_d = 32'd0;
    if (pipe_wr_en_i) begin
      if (!is_x0(pipe_waddr_i)) begin
        rf_wr_c_d  = 1'b1;
        rf_waddr_d = pipe_waddr_i;
        rf_wdata_d = pipe_wdata_i;
      end else begin
        rf_wr_c_d  = 1'b0;
      end
    end else if (head_win_s) begin
      rf_wr_c_d  = 1'b1;
      rf_waddr_d = fifo_head_s.addr;
      rf_wdata_d = fifo_head_s.data;
    end else begin
      rf_wr_c_d  = 1'b0;
    end
  end

  // Scoreboard next-state: a draining write clears its bit, a new issue sets (and overrides).
  always_comb begin
    busy_d = busy_q;
    if (head_win_s) begin
      busy_d[fifo_head_s.addr] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (aux_issue_i && !is_x0(aux_issue_addr_i)) begin
      busy_d[aux_issue_addr_i] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Starvation counter: counts cycles the queued head is blocked by the pipeline, saturating.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty_s || head_win_s) begin
      starve_d = SW'(0);
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q     <= {NUM_REGS{1'b0}};
      starve_q   <= SW'(0);
      rf_wr_c_q  <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      busy_q     <= busy_d;
      starve_q   <= starve_d;
      rf_wr_c_q  <= rf_wr_c_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  rf_wb_arbiter_chk #(.DEPTH(AUX_DEPTH), .CW(CW)) u_chk (
    .clk              (clk),
    .reset            (reset),
    .pipe_wr_en_i     (pipe_wr_en_i),
    .pipe_stall_i     (pipe_stall_o),
    .aux_issue_i      (aux_issue_i),
    .aux_issue_addr_i (aux_issue_addr_i),
    .busy_i           (busy_q),
    .count_i          (fifo_count_s)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_wr_en_i = 1'b0;
  logic [4:0]  pipe_waddr_i = 5'd0;
  logic [31:0] pipe_wdata_i = 32'd0;
  logic        aux_valid_i = 1'b0;
  logic        aux_ready_o;
  logic [4:0]  aux_waddr_i = 5'd0;
  logic [31:0] aux_wdata_i = 32'd0;
  logic        aux_issue_i = 1'b0;
  logic [4:0]  aux_issue_addr_i = 5'd0;
  logic [4:0]  chk_addr_1_i = 5'd0;
  logic [4:0]  chk_addr_2_i = 5'd0;
  logic        hazard_o;
  logic        pipe_stall_o;
  logic        rf_wr_c_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  int n_cmp = 0;
  int n_bad = 0;

  rf_wb_arbiter #(.AUX_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .pipe_wr_en_i     (pipe_wr_en_i),
    .pipe_waddr_i     (pipe_waddr_i),
    .pipe_wdata_i     (pipe_wdata_i),
    .aux_valid_i      (aux_valid_i),
    .aux_ready_o      (aux_ready_o),
    .aux_waddr_i      (aux_waddr_i),
    .aux_wdata_i      (aux_wdata_i),
    .aux_issue_i      (aux_issue_i),
    .aux_issue_addr_i (aux_issue_addr_i),
    .chk_addr_1_i     (chk_addr_1_i),
    .chk_addr_2_i     (chk_addr_2_i),
    .hazard_o         (hazard_o),
    .pipe_stall_o     (pipe_stall_o),
    .rf_wr_c_o        (rf_wr_c_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_o       (rf_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (rf_wr_c_o !== 1'b0) begin n_bad++; $display("FAIL reset_wr_c got=%0h exp=0", rf_wr_c_o); end
    n_cmp++; if (rf_waddr_o !== 5'd0) begin n_bad++; $display("FAIL reset_waddr got=%0h exp=0", rf_waddr_o); end
    n_cmp++; if (rf_wdata_o !== 32'd0) begin n_bad++; $display("FAIL reset_wdata got=%0h exp=0", rf_wdata_o); end
    n_cmp++; if (pipe_stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%0h exp=0", pipe_stall_o); end
    n_cmp++; if (aux_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%0h exp=1", aux_ready_o); end
    n_cmp++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL reset_hazard got=%0h exp=0", hazard_o); end
  endtask

  task automatic test_pipe_write();
    pipe_wr_en_i = 1'b1; pipe_waddr_i = 5'd5; pipe_wdata_i = 32'hDEADBEEF;
    #1;
    n_cmp++; if (rf_wr_c_o !== 1'b0) begin n_bad++; $display("FAIL pipe_early got=%0h exp=0", rf_wr_c_o); end
    tick();
    pipe_wr_en_i = 1'b0;
    n_cmp++; if (rf_wr_c_o !== 1'b1) begin n_bad++; $display("FAIL pipe_wr_c got=%0h exp=1", rf_wr_c_o); end
    n_cmp++; if (rf_waddr_o !== 5'd5) begin n_bad++; $display("FAIL pipe_waddr got=%0h exp=5", rf_waddr_o); end
    n_cmp++; if (rf_wdata_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL pipe_wdata got=%0h exp=deadbeef", rf_wdata_o); end
    tick();
    n_cmp++; if (rf_wr_c_o !== 1'b0) begin n_bad++; $display("FAIL pipe_idle got=%0h exp=0", rf_wr_c_o); end
  endtask

  task automatic test_aux_hazard();
    aux_issue_i = 1'b1; aux_issue_addr_i = 5'd7; chk_addr_1_i = 5'd7;
    #1;
    n_cmp++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL haz_noforward got=%0h exp=0", hazard_o); end
    tick();
    aux_issue_i = 1'b0;
    #1;
    n_cmp++; if (hazard_o !== 1'b1) begin n_bad++; $display("FAIL haz_set got=%0h exp=1", hazard_o); end
    chk_addr_1_i = 5'd0; chk_addr_2_i = 5'd7;
    #1;
    n_cmp++; if (hazard_o !== 1'b1) begin n_bad++; $display("FAIL haz_src2 got=%0h exp=1", hazard_o); end
    aux_valid_i = 1'b1; aux_waddr_i = 5'd7; aux_wdata_i = 32'h00001234;
    tick();
    aux_valid_i = 1'b0;
    n_cmp++; if (rf_wr_c_o !== 1'b0) begin n_bad++; $display("FAIL aux_nobypass got=%0h exp=0", rf_wr_c_o); end
    n_cmp++; if (hazard_o !== 1'b1) begin n_bad++; $display("FAIL haz_held got=%0h exp=1", hazard_o); end
    tick();
    n_cmp++; if (rf_wr_c_o !== 1'b1) begin n_bad++; $display("FAIL aux_wr_c got=%0h exp=1", rf_wr_c_o); end
    n_cmp++; if (rf_waddr_o !== 5'd7) begin n_bad++; $display("FAIL aux_waddr got=%0h exp=7", rf_waddr_o); end
    n_cmp++; if (rf_wdata_o !== 32'h00001234) begin n_bad++; $display("FAIL aux_wdata got=%0h exp=1234", rf_wdata_o); end
    n_cmp++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL haz_clear got=%0h exp=0", hazard_o); end
    chk_addr_2_i = 5'd0;
    tick();
  endtask

  task automatic test_starvation();
    pipe_wr_en_i = 1'b1; pipe_waddr_i = 5'd9; pipe_wdata_i = 32'h00000009;
    aux_valid_i = 1'b1; aux_waddr_i = 5'd10; aux_wdata_i = 32'h0000000A;
    tick();
    aux_valid_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (pipe_stall_o !== (k == 5)) begin n_bad++; $display("FAIL stall_pre%0d got=%0h exp=0", k, pipe_stall_o); end
      tick();
      n_cmp++; if (rf_waddr_o !== 5'd9) begin n_bad++; $display("FAIL starve_pipe%0d got=%0h exp=9", k, rf_waddr_o); end
    end
    n_cmp++; if (pipe_stall_o !== 1'b1) begin n_bad++; $display("FAIL stall_on got=%0h exp=1", pipe_stall_o); end
    pipe_wr_en_i = 1'b0;
    tick();
    n_cmp++; if (pipe_stall_o !== 1'b0) begin n_bad++; $display("FAIL stall_off got=%0h exp=0", pipe_stall_o); end
    n_cmp++; if (rf_wr_c_o !== 1'b1 || rf_waddr_o !== 5'd10 || rf_wdata_o !== 32'h0000000A) begin
      n_bad++; $display("FAIL starve_drain got=%0h/%0h/%0h exp=1/a/a", rf_wr_c_o, rf_waddr_o, rf_wdata_o);
    end
    tick();
  endtask

  task automatic test_fifo_full();
    pipe_wr_en_i = 1'b1; pipe_waddr_i = 5'd11; pipe_wdata_i = 32'h0000000B;
    aux_valid_i = 1'b1; aux_waddr_i = 5'd12; aux_wdata_i = 32'h0000000C;
    tick();
    aux_waddr_i = 5'd13; aux_wdata_i = 32'h0000000D;
    tick();
    n_cmp++; if (aux_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%0h exp=0", aux_ready_o); end
    aux_waddr_i = 5'd14; aux_wdata_i = 32'h0000000E;
    tick();
    n_cmp++; if (aux_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_hold got=%0h exp=0", aux_ready_o); end
    pipe_wr_en_i = 1'b0;
    tick();
    n_cmp++; if (rf_waddr_o !== 5'd12 || rf_wdata_o !== 32'h0000000C) begin n_bad++; $display("FAIL order1 got=%0h/%0h exp=c/c", rf_waddr_o, rf_wdata_o); end
    n_cmp++; if (aux_ready_o !== 1'b1) begin n_bad++; $display("FAIL ready_after got=%0h exp=1", aux_ready_o); end
    tick();
    aux_valid_i = 1'b0;
    n_cmp++; if (rf_waddr_o !== 5'd13 || rf_wdata_o !== 32'h0000000D) begin n_bad++; $display("FAIL order2 got=%0h/%0h exp=d/d", rf_waddr_o, rf_wdata_o); end
    n_cmp++; if (aux_ready_o !== 1'b1) begin n_bad++; $display("FAIL enqdeq_ready got=%0h exp=1", aux_ready_o); end
    tick();
    n_cmp++; if (rf_wr_c_o !== 1'b1 || rf_waddr_o !== 5'd14) begin n_bad++; $display("FAIL order3 got=%0h/%0h exp=1/e", rf_wr_c_o, rf_waddr_o); end
    tick();
    n_cmp++; if (rf_wr_c_o !== 1'b0) begin n_bad++; $display("FAIL fifo_empty got=%0h exp=0", rf_wr_c_o); end
  endtask

  task automatic test_x0();
    pipe_wr_en_i = 1'b1; pipe_waddr_i = 5'd0; pipe_wdata_i = 32'hFFFFFFFF;
    tick();
    pipe_wr_en_i = 1'b0;
    n_cmp++; if (rf_wr_c_o !== 1'b0) begin n_bad++; $display("FAIL x0_pipe got=%0h exp=0", rf_wr_c_o); end
    aux_valid_i = 1'b1; aux_waddr_i = 5'd0; aux_wdata_i = 32'h55555555;
    #1;
    n_cmp++; if (aux_ready_o !== 1'b1) begin n_bad++; $display("FAIL x0_handshake got=%0h exp=1", aux_ready_o); end
    tick();
    aux_valid_i = 1'b0;
    tick();
    n_cmp++; if (rf_wr_c_o !== 1'b0) begin n_bad++; $display("FAIL x0_aux got=%0h exp=0", rf_wr_c_o); end
    tick();
    n_cmp++; if (rf_wr_c_o !== 1'b0) begin n_bad++; $display("FAIL x0_aux_late got=%0h exp=0", rf_wr_c_o); end
    aux_issue_i = 1'b1; aux_issue_addr_i = 5'd0;
    tick();
    aux_issue_i = 1'b0; chk_addr_1_i = 5'd0;
    #1;
    n_cmp++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL x0_issue got=%0h exp=0", hazard_o); end
  endtask

  task automatic test_reset_midop();
    pipe_wr_en_i = 1'b1; pipe_waddr_i = 5'd1; pipe_wdata_i = 32'h00000001;
    aux_issue_i = 1'b1; aux_issue_addr_i = 5'd3;
    aux_valid_i = 1'b1; aux_waddr_i = 5'd20; aux_wdata_i = 32'h00000020;
    tick();
    aux_issue_i = 1'b0;
    aux_waddr_i = 5'd21; aux_wdata_i = 32'h00000021;
    tick();
    aux_valid_i = 1'b0; chk_addr_1_i = 5'd3;
    #1;
    n_cmp++; if (hazard_o !== 1'b1 || aux_ready_o !== 1'b0) begin n_bad++; $display("FAIL pre_reset got=%0h/%0h exp=1/0", hazard_o, aux_ready_o); end
    reset = 1'b0;
    #1;
    n_cmp++; if (rf_wr_c_o !== 1'b0 || rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0) begin
      n_bad++; $display("FAIL midrst_rf got=%0h/%0h/%0h exp=0/0/0", rf_wr_c_o, rf_waddr_o, rf_wdata_o);
    end
    n_cmp++; if (aux_ready_o !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got=%0h exp=1", aux_ready_o); end
    n_cmp++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL midrst_hazard got=%0h exp=0", hazard_o); end
    n_cmp++; if (pipe_stall_o !== 1'b0) begin n_bad++; $display("FAIL midrst_stall got=%0h exp=0", pipe_stall_o); end
    pipe_wr_en_i = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (rf_wr_c_o !== 1'b0) begin n_bad++; $display("FAIL midrst_flushed got=%0h exp=0", rf_wr_c_o); end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_aux_hazard();
    test_starvation();
    test_fifo_full();
    test_x0();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
